boron_decrypt_core: RTL and testbench

//  Iterative BORON-64/80 block decryptor that inverts the encryption datapath: inverse permutation layer (inverse XOR, inverse rotate, nibble-pair shuffle), inverse S-box layer and AddRoundKey.
//  It computes one round per cycle over 25 rounds.
//  It runs the key schedule forward on-chip to reach the final round key, then walks the schedule backwards.
//  It sits beside the encryption core in the cipher top and uses the same valid/ready stream interface.

---
 rtl/boron_pkg.sv | 95 +++++++++
 rtl/boron_inv_round.sv | 47 ++++
 rtl/boron_decrypt_core.sv | 97 +++++++++
 tb/tb_boron_decrypt_core.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boron_pkg.sv
// Shared BORON-64/80 constants, types and key-schedule helpers.
// Used by the decrypt core, its round datapath and the bench model.
package boron_pkg;

    localparam int ROUNDS  = 25;
    localparam int KEY_W   = 80;
    localparam int BLK_W   = 64;
    localparam int KEY_ROT = 13;

    localparam int ROT0 = 1;
    localparam int ROT1 = 4;
    localparam int ROT2 = 7;
    localparam int ROT3 = 9;

    localparam logic [4:0] RND_FIRST = 5'd1;
    localparam logic [4:0] RND_LAST  = 5'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        KEXP,
        DEC,
        DONE
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] w, input int n);
        return (w >> n) | (w << (16 - n));
    endfunction

    // Forward schedule step: rotate left, S-box low nibble, inject round index.
    function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                                 input logic [4:0] rc);
        logic [KEY_W-1:0] t;
        t = {k[KEY_W-KEY_ROT-1:0], k[KEY_W-1:KEY_W-KEY_ROT]};
        t[3:0] = sbox(t[3:0]);
        t[63:59] = t[63:59] ^ rc;
        return t;
    endfunction

    // Exact inverse of key_fwd for the same round index.
    function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                                 input logic [4:0] rc);
        logic [KEY_W-1:0] t;
        t = k;
        t[63:59] = t[63:59] ^ rc;
        t[3:0] = sbox_inv(t[3:0]);
        return {t[KEY_ROT-1:0], t[KEY_W-1:KEY_ROT]};
    endfunction

endpackage

// File: rtl/boron_inv_round.sv
// One combinational BORON decryption round:
// inverse P layer, inverse S layer, then AddRoundKey.
module boron_inv_round
    import boron_pkg::*;
(
    input  logic [BLK_W-1:0] st,
    input  logic [BLK_W-1:0] rk,
    output logic [BLK_W-1:0] res
);

    logic [15:0]      w0, w1, w2, w3;
    logic [15:0]      x0, x1, x2, x3;
    logic [15:0]      r0, r1, r2, r3;
    logic [BLK_W-1:0] p;
    logic [BLK_W-1:0] s;

    always_comb begin
        w0 = st[15:0];
        w1 = st[31:16];
        w2 = st[47:32];
        w3 = st[63:48];

        // The xor step uses the unmodified W0/W2, so it undoes itself.
        x0 = w0;
        x1 = w1 ^ w0;
        x2 = w2;
        x3 = w3 ^ w2;

        r0 = rotr16(x0, ROT0);
        r1 = rotr16(x1, ROT1);
        r2 = rotr16(x2, ROT2);
        r3 = rotr16(x3, ROT3);

        p = {r3[7:0], r3[15:8],
             r2[7:0], r2[15:8],
             r1[7:0], r1[15:8],
             r0[7:0], r0[15:8]};

        s = '0;
        for (int n = 0; n < 16; n++) begin
            s[4*n +: 4] = sbox_inv(p[4*n +: 4]);
        end

        res = s ^ rk;
    end

endmodule

// File: rtl/boron_decrypt_core.sv
// Iterative BORON-64/80 decryptor: runs the key schedule forward to RK26,
// then performs one inverse round per cycle while unwinding the schedule.
module boron_decrypt_core
    import boron_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_ct,
    input  logic [KEY_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_pt,
    output logic             busy
);

    state_t           state;
    logic [4:0]       rnd;
    logic [KEY_W-1:0] sched;
    logic [BLK_W-1:0] st;

    logic [KEY_W-1:0] key_next_fwd;
    logic [KEY_W-1:0] key_next_inv;
    logic [BLK_W-1:0] round_out;

    always_comb begin
        key_next_fwd = key_fwd(sched, rnd);
        key_next_inv = key_inv(sched, rnd);
    end

    boron_inv_round u_round (
        .st  (st),
        .rk  (key_next_inv[BLK_W-1:0]),
        .res (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rnd       <= '0;
            sched     <= '0;
            st        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_pt    <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        st       <= in_ct;
                        sched    <= in_key;
                        rnd      <= RND_FIRST;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= KEXP;
                    end
                end
                KEXP: begin
                    sched <= key_next_fwd;
                    if (rnd == RND_LAST) begin
                        // Whitening with RK26 happens as the last key step lands.
                        st    <= st ^ key_next_fwd[BLK_W-1:0];
                        state <= DEC;
                    end else begin
                        rnd <= rnd + 5'd1;
                    end
                end
                DEC: begin
                    sched <= key_next_inv;
                    st    <= round_out;
                    if (rnd == RND_FIRST) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        rnd <= rnd - 5'd1;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_pt    <= st;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boron_decrypt_core.sv
// Directed and round-trip checks for boron_decrypt_core against a
// bench-local BORON encryption model.
module tb_boron_decrypt_core;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_ct;
    logic [79:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pt;
    logic        busy;

    int checks;
    int errors;

    boron_decrypt_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ct     (in_ct),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pt    (out_pt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] SBOX_TBL = 64'h21748FE3DA09B65C;

    function automatic logic [3:0] m_s4(input logic [3:0] x);
        logic [63:0] t;
        t = SBOX_TBL;
        return t[4*x +: 4];
    endfunction

    function automatic logic [15:0] m_rotl(input logic [15:0] w, input int n);
        return (w << n) | (w >> (16 - n));
    endfunction

    function automatic logic [79:0] m_kf(input logic [79:0] k, input int r);
        logic [79:0] t;
        logic [4:0]  rc;
        rc = r[4:0];
        t = {k[66:0], k[79:67]};
        t[3:0] = m_s4(t[3:0]);
        t[63:59] = t[63:59] ^ rc;
        return t;
    endfunction

    function automatic logic [63:0] m_p(input logic [63:0] x);
        logic [15:0] w [4];
        int rot [4];
        rot = '{1, 4, 7, 9};
        for (int j = 0; j < 4; j++) begin
            w[j] = x[16*j +: 16];
            w[j] = {w[j][7:0], w[j][15:8]};
            w[j] = m_rotl(w[j], rot[j]);
        end
        w[1] = w[1] ^ w[0];
        w[3] = w[3] ^ w[2];
        return {w[3], w[2], w[1], w[0]};
    endfunction

    function automatic logic [63:0] m_enc(input logic [63:0] pt, input logic [79:0] key);
        logic [79:0] k;
        logic [63:0] s;
        logic [63:0] t;
        k = key;
        s = pt ^ k[63:0];
        for (int r = 1; r <= 25; r++) begin
            k = m_kf(k, r);
            t = '0;
            for (int n = 0; n < 16; n++) t[4*n +: 4] = m_s4(s[4*n +: 4]);
            s = m_p(t) ^ k[63:0];
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Submit one job, wait (bounded) for out_valid, return result and latency.
    task automatic run_job(input logic [63:0] ct, input logic [79:0] key,
                           input bit noise,
                           output logic [63:0] pt, output int lat);
        @(negedge clk);
        in_ct    = ct;
        in_key   = key;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (noise) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                in_ct     = {$urandom, $urandom};
                in_key    = {16'($urandom), $urandom, $urandom};
            end
            @(posedge clk);
            lat++;
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pt = out_pt;
        chk("latency", 80'(lat), 80'd51);
        chk("key_restored", dut.sched, key);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [79:0] key;
        logic [63:0] pt;
    } vec_t;

    initial begin
        vec_t        tbl [6];
        logic [63:0] ct;
        logic [63:0] pt;
        logic [63:0] held;
        int          lat;
        bit          stable;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ct     = '0;
        in_key    = '0;

        tbl[0] = '{80'h0, 64'h0};
        tbl[1] = '{80'h0123_4567_89AB_CDEF_0123, 64'h0011_2233_4455_6677};
        tbl[2] = '{80'hFFFF_0000_FFFF_0000_FFFF, 64'hDEAD_BEEF_CAFE_F00D};
        tbl[3] = '{80'h8000_0000_0000_0000_0001, 64'h8000_0000_0000_0001};
        tbl[4] = '{80'hA5A5_5A5A_A5A5_5A5A_A5A5, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[5] = '{80'h1357_9BDF_2468_ACE0_F00F, 64'h0F1E_2D3C_4B5A_6978};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 80'(in_ready), 80'd1);
        chk("rst_out_valid", 80'(out_valid), 80'd0);
        chk("rst_busy", 80'(busy), 80'd0);
        chk("rst_out_pt", 80'(out_pt), 80'd0);
        rst = 1'b0;

        // All-zero key and ciphertext; expected plaintext must re-encrypt to zero.
        run_job(64'h0, 80'h0, 1'b0, pt, lat);
        chk("zero_roundtrip", 80'(m_enc(pt, 80'h0)), 80'h0);
        release_out();

        for (int i = 0; i < 6; i++) begin
            ct = m_enc(tbl[i].pt, tbl[i].key);
            run_job(ct, tbl[i].key, 1'b0, pt, lat);
            chk($sformatf("table_pt[%0d]", i), 80'(pt), 80'(tbl[i].pt));
            release_out();
        end

        // Stall in DONE for 20 cycles.
        ct = m_enc(tbl[2].pt, tbl[2].key);
        run_job(ct, tbl[2].key, 1'b0, held, lat);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || out_pt !== held || in_ready) stable = 1'b0;
        end
        chk("stall_stable", 80'(stable), 80'd1);
        chk("stall_pt", 80'(held), 80'(tbl[2].pt));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("pulse_in_ready", 80'(in_ready), 80'd1);
        chk("pulse_out_valid", 80'(out_valid), 80'd0);

        // Reset in the middle of DEC at round 12.
        @(negedge clk);
        in_ct    = m_enc(tbl[1].pt, tbl[1].key);
        in_key   = tbl[1].key;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (38) @(posedge clk);
        @(negedge clk);
        chk("mid_rnd", 80'(dut.rnd), 80'd12);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", 80'(in_ready), 80'd1);
        chk("mid_rst_out_valid", 80'(out_valid), 80'd0);
        chk("mid_rst_busy", 80'(busy), 80'd0);
        ct = m_enc(tbl[3].pt, tbl[3].key);
        run_job(ct, tbl[3].key, 1'b0, pt, lat);
        chk("after_rst_pt", 80'(pt), 80'(tbl[3].pt));
        release_out();

        // Noise on in_valid/in_ct/out_ready while busy.
        ct = m_enc(tbl[5].pt, tbl[5].key);
        run_job(ct, tbl[5].key, 1'b1, pt, lat);
        chk("noise_pt", 80'(pt), 80'(tbl[5].pt));
        release_out();

        // All-ones key and ciphertext.
        run_job(64'hFFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, pt, lat);
        chk("ones_roundtrip", 80'(m_enc(pt, 80'hFFFF_FFFF_FFFF_FFFF_FFFF)),
            80'(64'hFFFF_FFFF_FFFF_FFFF));
        release_out();

        for (int i = 0; i < 1000; i++) begin
            logic [79:0] k;
            logic [63:0] p;
            k  = {16'($urandom), $urandom, $urandom};
            p  = {$urandom, $urandom};
            ct = m_enc(p, k);
            run_job(ct, k, 1'b0, pt, lat);
            chk("random_pt", 80'(pt), 80'(p));
            release_out();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
